// File: rtl/sipo_deserializer_pkg.sv
// Shared serial-link definitions: FSM encodings and default word width,
// common to the SIPO receiver and the PISO transmitter.
package sipo_deserializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int SIPO_WIDTH_DEF = 4;

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit shift register; dir=1 shifts toward the MSB (first bit ends in the
// MSB), dir=0 shifts toward the LSB (first bit ends in the LSB).
module sipo_shift_reg
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             si,
  output logic [WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] sr;

  // nxt is the value after this edge's shift; the top captures it as the
  // completed word on the edge that samples the last bit.
  always_comb begin
    nxt = dir ? {sr[WIDTH-2:0], si} : {si, sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (en) begin
      sr <= nxt;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: frames WIDTH bits after start, presents the
// word on q with a valid/ack handshake and a sticky overrun flag.
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             s_en,
  input  logic             start,
  input  logic             q_ack,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int                CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             shift_en;
  logic             load;
  logic             ovr_set;
  logic [WIDTH-1:0] word;

  sipo_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk(clk),
    .rst(rst),
    .en (shift_en),
    .dir(MSB_FIRST != 0),
    .si (si),
    .nxt(word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // start always wins: it (re)aligns the frame even on what would have been
  // the completing edge, so a partial word is never delivered.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shift_en = 1'b0;
    load     = 1'b0;
    ovr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          cnt_n = '0;
        end else if (s_en) begin
          shift_en = 1'b1;
          if (cnt == LAST) begin
            state_n = IDLE;
            cnt_n   = '0;
            if (!q_valid || q_ack) begin
              load = 1'b1;
            end else begin
              ovr_set = 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // A load in the same edge as q_ack keeps q_valid high for the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        q       <= word;
        q_valid <= 1'b1;
      end else if (q_ack) begin
        q_valid <= 1'b0;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share stimulus;
// directed table, asynchronous reset sequence, then random traffic vs a model.
module tb_sipo_deserializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         si = 1'b0, s_en = 1'b0, start = 1'b0, q_ack = 1'b0;
  logic [W-1:0] q_m, q_l;
  logic         qv_m, qv_l, busy_m, busy_l, ovr_m, ovr_l;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .si(si), .s_en(s_en), .start(start), .q_ack(q_ack),
    .q(q_m), .q_valid(qv_m), .busy(busy_m), .overrun(ovr_m)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .si(si), .s_en(s_en), .start(start), .q_ack(q_ack),
    .q(q_l), .q_valid(qv_l), .busy(busy_l), .overrun(ovr_l)
  );

  // Reference model: bits received since start, delivered as a word once W arrive.
  bit         m_inf;
  bit         m_bits[$];
  logic [W-1:0] m_qm, m_ql;
  bit         m_qv, m_ovr;

  task automatic model_reset();
    m_inf = 0; m_bits.delete(); m_qm = '0; m_ql = '0; m_qv = 0; m_ovr = 0;
  endtask

  task automatic model_step(input bit st, input bit en, input bit s, input bit a);
    bit loaded = 0;
    if (st) begin
      m_inf = 1;
      m_bits.delete();
    end else if (m_inf && en) begin
      m_bits.push_back(s);
      if (m_bits.size() == W) begin
        m_inf = 0;
        if (!m_qv || a) begin
          for (int i = 0; i < W; i++) begin
            m_qm[W-1-i] = m_bits[i];
            m_ql[i]     = m_bits[i];
          end
          m_qv   = 1;
          loaded = 1;
        end else begin
          m_ovr = 1;
        end
        m_bits.delete();
      end
    end
    if (a && !loaded) m_qv = 0;
  endtask

  task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] em, input logic [3:0] el,
                         input logic eqv, input logic eb, input logic eo);
    chk4({tag, " q msb"}, q_m, em);
    chk4({tag, " q lsb"}, q_l, el);
    chk1({tag, " q_valid msb"}, qv_m, eqv);
    chk1({tag, " q_valid lsb"}, qv_l, eqv);
    chk1({tag, " busy msb"}, busy_m, eb);
    chk1({tag, " busy lsb"}, busy_l, eb);
    chk1({tag, " overrun msb"}, ovr_m, eo);
    chk1({tag, " overrun lsb"}, ovr_l, eo);
  endtask

  // v = {start, s_en, si, q_ack}; inputs change 1 time unit after the edge.
  task automatic cycle(input logic [3:0] v);
    {start, s_en, si, q_ack} = v;
    model_step(v[3], v[2], v[1], v[0]);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] in;
    logic [3:0] qm;
    logic [3:0] ql;
    logic [2:0] fl;  // {q_valid, busy, overrun}
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] in, input logic [3:0] qm, input logic [3:0] ql,
                     input logic [2:0] fl);
    vec_t r;
    r.in = in; r.qm = qm; r.ql = ql; r.fl = fl;
    tbl.push_back(r);
  endtask

  initial begin
    // ack while nothing held; then 1,1,0,1
    add(4'b0001, 4'h0, 4'h0, 3'b000);
    add(4'b1000, 4'h0, 4'h0, 3'b010);
    add(4'b0110, 4'h0, 4'h0, 3'b010);
    add(4'b0110, 4'h0, 4'h0, 3'b010);
    add(4'b0100, 4'h0, 4'h0, 3'b010);
    add(4'b0110, 4'hD, 4'hB, 3'b100);
    add(4'b0000, 4'hD, 4'hB, 3'b100);
    // 0110 completes while 1101 is held -> overrun
    add(4'b1000, 4'hD, 4'hB, 3'b110);
    add(4'b0100, 4'hD, 4'hB, 3'b110);
    add(4'b0110, 4'hD, 4'hB, 3'b110);
    add(4'b0110, 4'hD, 4'hB, 3'b110);
    add(4'b0100, 4'hD, 4'hB, 3'b101);
    add(4'b0001, 4'hD, 4'hB, 3'b001);
    // 0011 after ack; overrun stays
    add(4'b1000, 4'hD, 4'hB, 3'b011);
    add(4'b0100, 4'hD, 4'hB, 3'b011);
    add(4'b0100, 4'hD, 4'hB, 3'b011);
    add(4'b0110, 4'hD, 4'hB, 3'b011);
    add(4'b0110, 4'h3, 4'hC, 3'b101);
    // completion together with ack: 1010 loads, q_valid stays
    add(4'b1000, 4'h3, 4'hC, 3'b111);
    add(4'b0110, 4'h3, 4'hC, 3'b111);
    add(4'b0100, 4'h3, 4'hC, 3'b111);
    add(4'b0110, 4'h3, 4'hC, 3'b111);
    add(4'b0101, 4'hA, 4'h5, 3'b101);
    add(4'b0001, 4'hA, 4'h5, 3'b001);
    // 1,0, three idle strobes, 1,1
    add(4'b1000, 4'hA, 4'h5, 3'b011);
    add(4'b0110, 4'hA, 4'h5, 3'b011);
    add(4'b0100, 4'hA, 4'h5, 3'b011);
    add(4'b0010, 4'hA, 4'h5, 3'b011);
    add(4'b0010, 4'hA, 4'h5, 3'b011);
    add(4'b0010, 4'hA, 4'h5, 3'b011);
    add(4'b0110, 4'hA, 4'h5, 3'b011);
    add(4'b0110, 4'hB, 4'hD, 3'b101);
    add(4'b0001, 4'hB, 4'hD, 3'b001);
    // restart after two bits (start beats s_en), then 0,1,1,0
    add(4'b1000, 4'hB, 4'hD, 3'b011);
    add(4'b0110, 4'hB, 4'hD, 3'b011);
    add(4'b0110, 4'hB, 4'hD, 3'b011);
    add(4'b1110, 4'hB, 4'hD, 3'b011);
    add(4'b0100, 4'hB, 4'hD, 3'b011);
    add(4'b0110, 4'hB, 4'hD, 3'b011);
    add(4'b0110, 4'hB, 4'hD, 3'b011);
    add(4'b0100, 4'h6, 4'h6, 3'b101);
    add(4'b0001, 4'h6, 4'h6, 3'b001);
    // start on the would-be completing edge, then 1,0,0,1
    add(4'b1000, 4'h6, 4'h6, 3'b011);
    add(4'b0110, 4'h6, 4'h6, 3'b011);
    add(4'b0110, 4'h6, 4'h6, 3'b011);
    add(4'b0110, 4'h6, 4'h6, 3'b011);
    add(4'b1110, 4'h6, 4'h6, 3'b011);
    add(4'b0110, 4'h6, 4'h6, 3'b011);
    add(4'b0100, 4'h6, 4'h6, 3'b011);
    add(4'b0100, 4'h6, 4'h6, 3'b011);
    add(4'b0110, 4'h9, 4'h9, 3'b101);

    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    #3 rst = 1'b0;

    foreach (tbl[i]) begin
      cycle(tbl[i].in);
      chk_all($sformatf("row%0d", i), tbl[i].qm, tbl[i].ql, tbl[i].fl[2], tbl[i].fl[1],
              tbl[i].fl[0]);
    end

    // Asynchronous reset three bits into a frame, with a word and overrun held.
    cycle(4'b1000);
    cycle(4'b0110);
    cycle(4'b0110);
    cycle(4'b0110);
    chk1("pre-reset busy", busy_m, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk_all("async reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    model_reset();
    {start, s_en, si, q_ack} = 4'b1111;
    @(posedge clk);
    #1;
    chk_all("reset held", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    #3 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(4'b0110);
      chk_all("no start after reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] v;
      v = {($urandom_range(15) == 0), ($urandom_range(3) != 0), 1'($urandom_range(1)),
           ($urandom_range(3) == 0)};
      cycle(v);
      chk_all($sformatf("rand%0d", i), m_qm, m_ql, m_qv, m_inf, m_ovr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of bits per parallel word (legal range 2..16).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 means the first received bit lands in q[WIDTH-1], 0 means it lands in q[0].
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port si, input, 1 bit: serial data in.
REQ-006 SHALL have port s_en, input, 1 bit: bit strobe; si is sampled on an edge where s_en=1 in SHIFT.
REQ-007 SHALL have port start, input, 1 bit: frame start, aligning the bit counter.
REQ-008 SHALL have port q_ack, input, 1 bit: consumer acknowledge of the held word.
REQ-009 SHALL have port q, output, WIDTH bits: last completed parallel word.
REQ-010 SHALL have port q_valid, output, 1 bit: q holds an unacknowledged word.
REQ-011 SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-012 SHALL have port overrun, output, 1 bit: sticky; a word completed while q_valid=1.

Function
REQ-013 SHALL implement FSM states IDLE and SHIFT, with busy = (state==SHIFT).
REQ-014 IDLE: start=1 -> SHIFT with bit counter=0; si and s_en in that cycle are ignored.
REQ-015 SHIFT: on each edge with s_en=1, SHALL shift si into an internal shift register (direction per MSB_FIRST) and increment the counter; s_en=0 holds all state.
REQ-016 On the edge sampling bit WIDTH (counter==WIDTH-1), SHALL return to IDLE and, if q_valid=0 or q_ack=1 that cycle, load q with the completed word and set q_valid=1.
REQ-017 Latency: q and q_valid SHALL update on the same edge that samples the last bit, so they are visible in the following cycle.
REQ-018 q_valid SHALL remain 1 until an edge with q_ack=1; q SHALL remain stable while q_valid=1.
REQ-019 q_ack=1 while q_valid=0 SHALL have no effect.
REQ-020 Word completes while q_valid=1 and q_ack=0: the new word SHALL be discarded, q SHALL be unchanged, and overrun SHALL be set to 1.
REQ-021 Completion and q_ack=1 in the same edge: the new word SHALL load, q_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-022 overrun SHALL be cleared only by reset.
REQ-023 start=1 in SHIFT SHALL abort the partial word (discarded, no q_valid), zero the counter and stay in SHIFT; start takes priority over s_en in that cycle.
REQ-024 start=1 on the edge that would complete a word SHALL abort per REQ-023; no word is delivered.
REQ-025 The counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, counter=0, shift register=0, q=0, q_valid=0, busy=0 and overrun=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial word; after release, no word is accepted until a new start.
REQ-028 Outputs SHALL hold their reset values while rst=1, regardless of start, s_en and q_ack.

Structure
REQ-029 The state encodings (IDLE=1'b0, SHIFT=1'b1) and the default WIDTH SHALL reside in the team's shared definitions file, also used by the PISO transmitter.
REQ-030 A single sub-module, sipo_shift_reg, SHALL hold the WIDTH-bit shift register with ports clk, rst, en, dir and si; FSM, counter and handshake stay in the top module.

Verification
REQ-031 Scenario: WIDTH=4, MSB_FIRST=1, start, then s_en=1 with si=1,1,0,1 on consecutive cycles -> q=4'b1101 and q_valid=1 in the cycle after the 4th bit, busy=0.
REQ-032 Scenario: same bits with MSB_FIRST=0 -> q=4'b1011.
REQ-033 Scenario: bits 1,0 sent, s_en=0 for 3 cycles, then bits 1,1 -> q=4'b1011; no q_valid before the 4th bit.
REQ-034 Scenario: word 4'b1101 held unacknowledged, second word 4'b0110 completes -> q stays 4'b1101 and overrun=1; after q_ack and a third word 4'b0011, q=4'b0011 and overrun is still 1.
REQ-035 Scenario: start reasserted after 2 bits, then 4 bits 0,1,1,0 -> q=4'b0110 and exactly one q_valid rise.
REQ-036 Scenario: rst pulsed between clock edges after 3 bits -> all outputs 0 immediately; no word is delivered from subsequent s_en until a new start.
